// File: rtl/fetch_stage.sv
// fetch_stage: PC generation, credit-limited imem requests, and a response FIFO feeding decode.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        busy
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [31:0] fetch_pc;
    logic [31:0] pend_pc [DEPTH];
    logic [31:0] fifo_pc [DEPTH];
    logic [31:0] fifo_instr [DEPTH];
    logic [AW-1:0] pq_wr, pq_rd, wr_ptr, rd_ptr;
    logic [CW-1:0] count, outstanding, stale_cnt;
    logic [CW:0] used;
    logic req_fire, rsp_take, push, pop;
    logic unused_bits;
    assign unused_bits = ^redirect_pc[1:0];
    // Credits cover both buffered words and words still in flight, so the FIFO can never overflow.
    assign used = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = !rst && !redirect_valid && (used < (CW+1)'(DEPTH));
    assign imem_req_addr = fetch_pc;
    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_take = imem_rsp_valid && (outstanding != '0);
    assign push = rsp_take && (stale_cnt == '0) && !redirect_valid;
    assign dec_valid = count != '0;
    assign pop = dec_valid && dec_ready;
    assign dec_instr = dec_valid ? fifo_instr[rd_ptr] : '0;
    assign dec_pc = dec_valid ? fifo_pc[rd_ptr] : '0;
    assign busy = (outstanding != '0) || (stale_cnt != '0);
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pq_wr <= '0;
            pq_rd <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            outstanding <= '0;
            stale_cnt <= '0;
        end else begin
            fetch_pc <= redirect_valid ? {redirect_pc[31:2], 2'b00} : req_fire ? fetch_pc + 32'd4 : fetch_pc;
            pq_wr <= pq_wr + AW'(req_fire);
            pq_rd <= pq_rd + AW'(rsp_take);
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= redirect_valid ? wr_ptr : rd_ptr + AW'(pop);
            count <= redirect_valid ? '0 : count + CW'(push) - CW'(pop);
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
            // Everything still in flight at a redirect belongs to the abandoned path.
            stale_cnt <= redirect_valid ? outstanding - CW'(rsp_take)
                                        : stale_cnt - CW'(rsp_take && (stale_cnt != '0));
        end
    end
    always_ff @(posedge clk) begin
        if (req_fire) pend_pc[pq_wr] <= fetch_pc;
        if (push) begin
            fifo_pc[wr_ptr] <= pend_pc[pq_rd];
            fifo_instr[wr_ptr] <= imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and random checks of fetch_stage against an in-order memory and a PC-path model.
module tb_fetch_stage;
    localparam int DEPTH = 4;
    logic clk = 0;
    logic rst = 1;
    logic imem_req_valid, imem_req_ready = 0;
    logic [31:0] imem_req_addr;
    logic imem_rsp_valid = 0;
    logic [31:0] imem_rsp_data = 0;
    logic redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic dec_valid, dec_ready = 0;
    logic [31:0] dec_instr, dec_pc;
    logic busy;

    fetch_stage #(.RESET_PC(32'h0), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_instr(dec_instr), .dec_pc(dec_pc),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int due;
    } mreq_t;
    mreq_t mq[$];
    logic [31:0] dec_log[$];
    int cyc = 0;
    int checks = 0, errors = 0;
    int bench_out = 0, req_cnt = 0, dec_cnt = 0;
    int first_req_cyc = -1, first_dec_cyc = -1;
    int rdy_pct = 100, lat_min = 1, lat_max = 1;
    logic [31:0] exp_pc = 0, exp_req = 0;
    logic hold = 0;
    logic [31:0] hold_pc = 0, hold_instr = 0;

    function automatic logic [31:0] img(logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h9E37_79B9 ^ (a * 3);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory: random request acceptance, in-order responses after a per-request latency.
    always @(posedge clk) begin
        #1;
        imem_req_ready = ($urandom_range(99) < rdy_pct);
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1;
            imem_rsp_data = img(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 0;
            imem_rsp_data = $urandom;
        end
    end

    // Monitor: follows the redirect-defined PC path and checks requests and the decode stream.
    always @(negedge clk) begin
        if (rst) begin
            mq.delete();
            dec_log.delete();
            bench_out = 0;
            req_cnt = 0;
            dec_cnt = 0;
            first_req_cyc = -1;
            first_dec_cyc = -1;
            exp_pc = 0;
            exp_req = 0;
            hold = 0;
        end else begin
            if (imem_rsp_valid) begin
                assert (bench_out > 0) else $error("FAIL protocol: response with nothing outstanding");
                bench_out--;
            end
            if (redirect_valid) chk("no_req_on_redirect", 32'(imem_req_valid), 0);
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, exp_req);
                mq.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_max, lat_min))});
                exp_req += 4;
                bench_out++;
                req_cnt++;
                if (first_req_cyc < 0) first_req_cyc = cyc;
                chk("credit", 32'(bench_out <= DEPTH), 1);
            end
            if (hold) begin
                chk("stall_valid", 32'(dec_valid), 1);
                chk("stall_pc", dec_pc, hold_pc);
                chk("stall_instr", dec_instr, hold_instr);
            end
            if (dec_valid && first_dec_cyc < 0) first_dec_cyc = cyc;
            if (dec_valid && dec_ready) begin
                chk("dec_pc", dec_pc, exp_pc);
                chk("dec_instr", dec_instr, img(exp_pc));
                dec_log.push_back(dec_pc);
                dec_cnt++;
                exp_pc += 4;
            end
            if (redirect_valid) begin
                exp_pc = {redirect_pc[31:2], 2'b00};
                exp_req = {redirect_pc[31:2], 2'b00};
            end
            hold = dec_valid && !dec_ready && !redirect_valid;
            hold_pc = dec_pc;
            hold_instr = dec_instr;
        end
    end

    task automatic cycles(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        redirect_valid = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(imem_req_valid), 0);
        chk("rst_req_addr", imem_req_addr, 0);
        chk("rst_dec_valid", 32'(dec_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dec_pc", dec_pc, 0);
        chk("rst_dec_instr", dec_instr, 0);
        @(posedge clk);
        #1;
        rst = 0;
    endtask

    function automatic logic [31:0] log_at(int i);
        return (i >= 0 && i < dec_log.size()) ? dec_log[i] : 32'hDEAD_BEEF;
    endfunction

    initial begin
        int n;
        // Streaming with a single-cycle memory.
        dec_ready = 1; rdy_pct = 100; lat_min = 1; lat_max = 1;
        do_reset();
        cycles(10);
        chk("t1_latency", first_dec_cyc - first_req_cyc, 2);
        chk("t1_pc0", log_at(0), 32'h0);
        chk("t1_pc2", log_at(2), 32'h8);
        n = dec_cnt;
        cycles(20);
        chk("t1_throughput", dec_cnt - n, 20);

        // Decode stall fills the credit window exactly.
        dec_ready = 0;
        do_reset();
        cycles(10);
        chk("t2_reqs", req_cnt, 4);
        chk("t2_dec_valid", 32'(dec_valid), 1);
        chk("t2_dec_pc", dec_pc, 32'h0);
        chk("t2_busy", 32'(busy), 0);
        dec_ready = 1;
        cycles(12);
        chk("t2_pop3", log_at(3), 32'hC);
        chk("t2_resume", log_at(4), 32'h10);

        // Redirect over two slow in-flight requests.
        lat_min = 3; lat_max = 3;
        do_reset();
        cycles(2);
        redirect_valid = 1; redirect_pc = 32'h103;
        cycles(1);
        redirect_valid = 0;
        chk("t3_busy", 32'(busy), 1);
        cycles(15);
        chk("t3_first_pc", log_at(0), 32'h100);
        chk("t3_second_pc", log_at(1), 32'h104);

        // Redirect coinciding with a response and a decode handshake.
        lat_min = 1; lat_max = 1;
        do_reset();
        cycles(10);
        redirect_valid = 1; redirect_pc = 32'h200;
        @(negedge clk);
        #1;
        chk("t4_pre", 32'(imem_rsp_valid && dec_valid && dec_ready), 1);
        n = dec_cnt;
        @(posedge clk);
        #1;
        redirect_valid = 0;
        chk("t4_flushed", 32'(dec_valid), 0);
        cycles(8);
        chk("t4_popped", log_at(n - 1), 32'h20);
        chk("t4_next_pc", log_at(n), 32'h200);

        // Address wrap at the top of the space.
        redirect_valid = 1; redirect_pc = 32'hFFFF_FFF8;
        cycles(1);
        redirect_valid = 0;
        n = dec_cnt;
        cycles(8);
        chk("t5_pc0", log_at(n), 32'hFFFF_FFF8);
        chk("t5_pc1", log_at(n + 1), 32'hFFFF_FFFC);
        chk("t5_pc2", log_at(n + 2), 32'h0000_0000);

        // Random memory timing, decode stalls and redirects.
        rdy_pct = 70; lat_min = 1; lat_max = 4;
        n = dec_cnt;
        for (int i = 0; i < 10000; i++) begin
            dec_ready = ($urandom_range(99) < 75);
            redirect_valid = ($urandom_range(99) < 3);
            redirect_pc = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : $urandom;
            cycles(1);
        end
        dec_ready = 1; redirect_valid = 0;
        cycles(30);
        chk("t6_progress", 32'((dec_cnt - n) > 1000), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
